// File: rtl/control_unit.sv
// Multi-cycle control unit for a small accumulator CPU: FETCH/EXEC sequencing,
// instruction decode, program counter and run statistics.
module control_unit #(
    parameter int NBITS_O   = 11,
    parameter int NBITS_D   = 16,
    parameter int NBITS_PC  = 11,
    parameter int NBITS_OPC = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NBITS_D-1:0]  i_Instruction,
    output logic [NBITS_PC-1:0] o_PC,
    output logic [NBITS_O-1:0]  o_Operand,
    output logic [1:0]          o_SelA,
    output logic                o_SelB,
    output logic                o_WrAcc,
    output logic                o_Op,
    output logic                o_WrRam,
    output logic                o_RdRam,
    output logic                o_busy,
    output logic                o_done,
    output logic [NBITS_D-1:0]  o_cycles,
    output logic [NBITS_D-1:0]  o_retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [NBITS_OPC-1:0] OPC_HLT  = NBITS_OPC'(0);
    localparam logic [NBITS_OPC-1:0] OPC_STO  = NBITS_OPC'(1);
    localparam logic [NBITS_OPC-1:0] OPC_LD   = NBITS_OPC'(2);
    localparam logic [NBITS_OPC-1:0] OPC_LDI  = NBITS_OPC'(3);
    localparam logic [NBITS_OPC-1:0] OPC_ADD  = NBITS_OPC'(4);
    localparam logic [NBITS_OPC-1:0] OPC_ADDI = NBITS_OPC'(5);
    localparam logic [NBITS_OPC-1:0] OPC_SUB  = NBITS_OPC'(6);
    localparam logic [NBITS_OPC-1:0] OPC_SUBI = NBITS_OPC'(7);

    localparam logic [1:0] SELA_MEM  = 2'b00;
    localparam logic [1:0] SELA_IMM  = 2'b01;
    localparam logic [1:0] SELA_ALU  = 2'b10;
    localparam logic [1:0] SELA_HOLD = 2'b11;

    localparam logic [NBITS_D-1:0] CNT_MAX = '1;

    state_t               state;
    logic [NBITS_PC-1:0]  pc;
    logic [NBITS_D-1:0]   cycles;
    logic [NBITS_D-1:0]   retired;
    logic [NBITS_OPC-1:0] opcode;

    assign opcode = i_Instruction[NBITS_D-1 -: NBITS_OPC];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            cycles  <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    // A start from HALT is a full restart of the program.
                    if (i_start) begin
                        state   <= S_FETCH;
                        pc      <= '0;
                        cycles  <= '0;
                        retired <= '0;
                    end
                end
                S_FETCH: begin
                    state  <= S_EXEC;
                    cycles <= (cycles == CNT_MAX) ? cycles : cycles + 1'b1;
                end
                S_EXEC: begin
                    cycles  <= (cycles == CNT_MAX) ? cycles : cycles + 1'b1;
                    retired <= (retired == CNT_MAX) ? retired : retired + 1'b1;
                    if (opcode == OPC_HLT) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                        pc    <= pc + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The ROM is synchronous, so the instruction is only valid during EXEC and
    // the controls must be decoded combinationally from it in that cycle.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_SelA  = SELA_HOLD;
        o_SelB  = 1'b0;
        o_WrAcc = 1'b0;
        o_Op    = 1'b0;
        o_WrRam = 1'b0;
        o_RdRam = 1'b0;
        if (state == S_EXEC) begin
            case (opcode)
                OPC_STO: o_WrRam = 1'b1;
                OPC_LD: begin
                    o_RdRam = 1'b1;
                    o_SelA  = SELA_MEM;
                    o_WrAcc = 1'b1;
                end
                OPC_LDI: begin
                    o_SelA  = SELA_IMM;
                    o_WrAcc = 1'b1;
                end
                OPC_ADD: begin
                    o_RdRam = 1'b1;
                    o_SelA  = SELA_ALU;
                    o_WrAcc = 1'b1;
                end
                OPC_ADDI: begin
                    o_SelB  = 1'b1;
                    o_SelA  = SELA_ALU;
                    o_WrAcc = 1'b1;
                end
                OPC_SUB: begin
                    o_RdRam = 1'b1;
                    o_Op    = 1'b1;
                    o_SelA  = SELA_ALU;
                    o_WrAcc = 1'b1;
                end
                OPC_SUBI: begin
                    o_SelB  = 1'b1;
                    o_Op    = 1'b1;
                    o_SelA  = SELA_ALU;
                    o_WrAcc = 1'b1;
                end
                default: ;  // HLT and unknown opcodes write nothing
            endcase
        end
    end

    assign o_PC      = pc;
    assign o_Operand = i_Instruction[NBITS_O-1:0];
    assign o_busy    = (state == S_FETCH) || (state == S_EXEC);
    assign o_done    = (state == S_HALT);
    assign o_cycles  = cycles;
    assign o_retired = retired;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a synchronous ROM model feeds directed
// programs; a negedge monitor compares every busy cycle against queued expectations.
module tb_control_unit;

    localparam int NO   = 11;
    localparam int ND   = 16;
    localparam int NPC  = 11;
    localparam int NOPC = 5;

    // {SelA, SelB, WrAcc, Op, WrRam, RdRam}
    localparam logic [6:0] C_NONE = 7'b1100000;
    localparam logic [6:0] C_STO  = 7'b1100010;
    localparam logic [6:0] C_LD   = 7'b0001001;
    localparam logic [6:0] C_LDI  = 7'b0101000;
    localparam logic [6:0] C_ADD  = 7'b1001001;
    localparam logic [6:0] C_ADDI = 7'b1011000;
    localparam logic [6:0] C_SUB  = 7'b1001101;
    localparam logic [6:0] C_SUBI = 7'b1011100;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [ND-1:0]  instr;
    logic [NPC-1:0] o_pc;
    logic [NO-1:0]  o_operand;
    logic [1:0]     o_sel_a;
    logic           o_sel_b, o_wr_acc, o_op, o_wr_ram, o_rd_ram, o_busy, o_done;
    logic [ND-1:0]  o_cycles, o_retired;

    logic [ND-1:0]  rom [0:2047];
    logic [31:0]    exp_q [$];
    int             n_checks = 0;
    int             n_errors = 0;
    bit             mon_en = 1'b1;

    always #5 clk = ~clk;

    control_unit #(.NBITS_O(NO), .NBITS_D(ND), .NBITS_PC(NPC), .NBITS_OPC(NOPC)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_Instruction(instr),
        .o_PC(o_pc), .o_Operand(o_operand), .o_SelA(o_sel_a), .o_SelB(o_sel_b),
        .o_WrAcc(o_wr_acc), .o_Op(o_op), .o_WrRam(o_wr_ram), .o_RdRam(o_rd_ram),
        .o_busy(o_busy), .o_done(o_done), .o_cycles(o_cycles), .o_retired(o_retired)
    );

    always @(posedge clk) instr <= rom[o_pc];

    function automatic logic [6:0] ctl_now();
        return {o_sel_a, o_sel_b, o_wr_acc, o_op, o_wr_ram, o_rd_ram};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entry: {is_exec, done, 1'b0, ctl[6:0], pc[10:0], operand[10:0]}
    task automatic push_fetch(input int pc);
        exp_q.push_back({1'b0, 1'b0, 1'b0, C_NONE, 11'(pc), 11'h0});
    endtask

    task automatic push_exec(input int pc, input logic [6:0] ctl, input int opnd);
        exp_q.push_back({1'b1, 1'b0, 1'b0, ctl, 11'(pc), 11'(opnd)});
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en && o_busy) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_busy_cycle", {21'h0, o_pc}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_cycle", {e[31], o_done, 1'b0, ctl_now(), o_pc,
                                   e[31] ? o_operand : 11'h0}, e);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!o_done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", {31'h0, o_done}, 32'h1);
    endtask

    task automatic check_end(input int pc, input int ret, input int cyc);
        check("end_pc", {21'h0, o_pc}, pc);
        check("end_retired", {16'h0, o_retired}, ret);
        check("end_cycles", {16'h0, o_cycles}, cyc);
        check("end_busy_done", {30'h0, o_busy, o_done}, 32'h1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pc_bad;
        bit  seen_wrap;
        logic [NPC-1:0] prev_pc;

        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {25'h0, ctl_now()}, {25'h0, C_NONE});
        check("reset_busy_done", {30'h0, o_busy, o_done}, 32'h0);
        check("reset_pc", {21'h0, o_pc}, 0);
        check("reset_counters", {o_cycles, o_retired}, 0);

        // Reset wins over start in the same cycle.
        start = 1'b1;
        @(negedge clk);
        check("rst_prio_busy_done", {30'h0, o_busy, o_done}, 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_stays_idle", {30'h0, o_busy, o_done}, 32'h0);

        // LDI 5; ADDI 3; STO 0x010; HLT
        rom[0] = 16'h1805; rom[1] = 16'h2803; rom[2] = 16'h0810; rom[3] = 16'h0000;
        push_fetch(0); push_exec(0, C_LDI, 5);
        push_fetch(1); push_exec(1, C_ADDI, 3);
        push_fetch(2); push_exec(2, C_STO, 16);
        push_fetch(3); push_exec(3, C_NONE, 0);
        pulse_start();
        wait_done(40);
        check_end(3, 4, 8);
        repeat (3) @(negedge clk);
        check("halt_holds_cycles", {16'h0, o_cycles}, 8);
        check("halt_holds_done", {31'h0, o_done}, 1);

        // LD; ADD; SUB; SUBI; unknown opcode; HLT -- start held high throughout
        rom[0] = 16'h1020; rom[1] = 16'h2021; rom[2] = 16'h3022;
        rom[3] = 16'h3807; rom[4] = 16'hF8AB; rom[5] = 16'h0000;
        push_fetch(0); push_exec(0, C_LD, 12'h020);
        push_fetch(1); push_exec(1, C_ADD, 12'h021);
        push_fetch(2); push_exec(2, C_SUB, 12'h022);
        push_fetch(3); push_exec(3, C_SUBI, 7);
        push_fetch(4); push_exec(4, C_NONE, 12'h0AB);
        push_fetch(5); push_exec(5, C_NONE, 0);
        start = 1'b1;
        @(negedge clk);
        wait_done(60);
        start = 1'b0;
        check_end(5, 6, 12);

        // Opcode 11111 at PC 0, then HLT; restart via pulse clears PC and counters
        rom[0] = 16'hFFFF; rom[1] = 16'h0000;
        push_fetch(0); push_exec(0, C_NONE, 12'h7FF);
        push_fetch(1); push_exec(1, C_NONE, 0);
        pulse_start();
        wait_done(20);
        check_end(1, 2, 4);

        // Reset during the EXEC of an LD
        rom[0] = 16'h1020;
        push_fetch(0); push_exec(0, C_LD, 12'h020);
        pulse_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midexec_rst_busy_done", {30'h0, o_busy, o_done}, 0);
        check("midexec_rst_pc", {21'h0, o_pc}, 0);
        check("midexec_rst_counters", {o_cycles, o_retired}, 0);
        check("midexec_rst_ctl", {25'h0, ctl_now()}, {25'h0, C_NONE});
        check("midexec_sb_drained", exp_q.size(), 0);
        rst = 1'b0;

        // NOP-filled ROM: PC must wrap 0x7FF -> 0x000 while staying busy
        for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
        mon_en    = 1'b0;
        pc_bad    = 0;
        seen_wrap = 1'b0;
        prev_pc   = '0;
        pulse_start();
        for (int k = 0; k <= 4097; k++) begin
            if (k > 0) @(negedge clk);
            if (o_pc !== NPC'((k / 2) % 2048) || o_busy !== 1'b1) pc_bad++;
            if (prev_pc == 11'h7FF && o_pc == 11'h000) seen_wrap = 1'b1;
            prev_pc = o_pc;
        end
        check("wrap_pc_busy_track", pc_bad, 0);
        check("wrap_seen", {31'h0, seen_wrap}, 1);
        check("wrap_cycles", {16'h0, o_cycles}, 4097);
        check("wrap_retired", {16'h0, o_retired}, 2048);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
